// File: rtl/usb_rx_decoder.sv
// USB receive line decoder: SYNC detection, NRZI decode, bit unstuffing,
// EOP detection and error flagging, feeding a serial bit stream downstream.
module usb_rx_decoder #(
    parameter logic [7:0]  SYNC_PATTERN = 8'b0000_0001,
    parameter int unsigned STUFF_LEN    = 6,
    parameter int unsigned EOP_SE0_MIN  = 2,
    parameter int unsigned MAX_BITS     = 99,
    parameter int unsigned IDLE_J_LEN   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       dp,
    input  logic       dm,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       pkt_start,
    output logic       sync_ok,
    output logic       pkt_done,
    output logic       err,
    output logic [2:0] err_code,
    output logic [6:0] bit_count,
    output logic       busy
);

    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
    localparam int unsigned SE0_W  = $clog2(EOP_SE0_MIN + 1);
    localparam int unsigned JCNT_W = $clog2(IDLE_J_LEN);
    localparam int unsigned CNT_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } state_e;

    state_e              state_q;
    logic                prev_j_q;
    logic [ONES_W-1:0]   ones_cnt_q;
    logic [2:0]          sync_cnt_q;
    logic [SE0_W-1:0]    se0_cnt_q;
    logic [JCNT_W-1:0]   j_cnt_q;
    logic                bit_out_q;
    logic                bit_valid_q;
    logic                pkt_start_q;
    logic                sync_ok_q;
    logic                pkt_done_q;
    logic                err_q;
    logic [2:0]          err_code_q;
    logic [CNT_W-1:0]    bit_count_q;
    logic                busy_q;

    logic   line_j_c, line_k_c, line_se0_c, line_se1_c, line_jk_c;
    logic   dec_c, sync_exp_c, stuff_due_c;
    logic   err_fire_c;
    logic   [2:0] err_code_c;
    state_e state_nxt_c;

    // Line classification, NRZI decode, error detection and next state
    always_comb begin
        line_j_c    = dp & ~dm;
        line_k_c    = ~dp & dm;
        line_se0_c  = ~dp & ~dm;
        line_se1_c  = dp & dm;
        line_jk_c   = line_j_c | line_k_c;
        dec_c       = (line_j_c == prev_j_q);
        sync_exp_c  = SYNC_PATTERN[~sync_cnt_q];
        stuff_due_c = (ones_cnt_q == ONES_W'(STUFF_LEN));
        err_fire_c  = 1'b0;
        err_code_c  = 3'd0;
        state_nxt_c = state_q;

        if (rx_en) begin
            case (state_q)
                ST_SYNC, ST_DATA: begin
                    if (line_se1_c) begin
                        err_fire_c = 1'b1;
                        err_code_c = 3'd5;
                    end else if (line_se0_c && state_q == ST_SYNC) begin
                        err_fire_c = 1'b1;
                        err_code_c = 3'd3;
                    end else if (line_jk_c) begin
                        if (stuff_due_c) begin
                            if (dec_c) begin
                                err_fire_c = 1'b1;
                                err_code_c = 3'd1;
                            end
                        end else if (state_q == ST_SYNC && dec_c != sync_exp_c) begin
                            err_fire_c = 1'b1;
                            err_code_c = 3'd2;
                        end else if (bit_count_q == CNT_W'(MAX_BITS)) begin
                            err_fire_c = 1'b1;
                            err_code_c = 3'd4;
                        end
                    end
                end
                ST_EOP: begin
                    if (line_se1_c) begin
                        err_fire_c = 1'b1;
                        err_code_c = 3'd5;
                    end else if (line_k_c ||
                                 (line_j_c && se0_cnt_q < SE0_W'(EOP_SE0_MIN))) begin
                        err_fire_c = 1'b1;
                        err_code_c = 3'd3;
                    end
                end
                default: ;
            endcase
        end

        if (!rx_en) begin
            state_nxt_c = ST_IDLE;
        end else if (err_fire_c) begin
            state_nxt_c = ST_ERR;
        end else begin
            case (state_q)
                ST_IDLE: if (line_k_c) state_nxt_c = ST_SYNC;
                ST_SYNC: if (line_jk_c && !stuff_due_c && sync_cnt_q == 3'd7)
                             state_nxt_c = ST_DATA;
                ST_DATA: if (line_se0_c) state_nxt_c = ST_EOP;
                ST_EOP:  if (line_j_c) state_nxt_c = ST_IDLE;
                ST_ERR:  if (line_j_c && (se0_cnt_q != '0 ||
                                          j_cnt_q == JCNT_W'(IDLE_J_LEN - 1)))
                             state_nxt_c = ST_IDLE;
                default: state_nxt_c = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_j_q    <= 1'b1;
            ones_cnt_q  <= '0;
            sync_cnt_q  <= '0;
            se0_cnt_q   <= '0;
            j_cnt_q     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            pkt_start_q <= 1'b0;
            sync_ok_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            bit_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            pkt_start_q <= 1'b0;
            sync_ok_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= state_nxt_c;
            busy_q      <= (state_nxt_c != ST_IDLE);

            if (line_jk_c) prev_j_q <= line_j_c;
            // Line is idle (J) after any exit from EOP
            if (rx_en && state_q == ST_EOP && state_nxt_c != ST_EOP) prev_j_q <= 1'b1;

            if (!rx_en) begin
                ones_cnt_q <= '0;
                sync_cnt_q <= '0;
                se0_cnt_q  <= '0;
                j_cnt_q    <= '0;
            end else if (err_fire_c) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_c;
                se0_cnt_q  <= '0;
                j_cnt_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (line_k_c) begin
                            bit_valid_q <= 1'b1;
                            pkt_start_q <= 1'b1;
                            bit_count_q <= CNT_W'(1);
                            sync_cnt_q  <= 3'd1;
                            ones_cnt_q  <= '0;
                        end
                    end
                    ST_SYNC, ST_DATA: begin
                        if (line_se0_c) begin
                            se0_cnt_q <= SE0_W'(1);
                        end else if (line_jk_c) begin
                            if (stuff_due_c) begin
                                ones_cnt_q <= '0;
                            end else begin
                                bit_valid_q <= 1'b1;
                                bit_out_q   <= dec_c;
                                bit_count_q <= bit_count_q + CNT_W'(1);
                                ones_cnt_q  <= dec_c ? ones_cnt_q + ONES_W'(1) : '0;
                                if (state_q == ST_SYNC) begin
                                    sync_cnt_q <= sync_cnt_q + 3'd1;
                                    if (sync_cnt_q == 3'd7) sync_ok_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_EOP: begin
                        if (line_se0_c && se0_cnt_q != SE0_W'(EOP_SE0_MIN))
                            se0_cnt_q <= se0_cnt_q + SE0_W'(1);
                        if (line_j_c) pkt_done_q <= 1'b1;
                    end
                    ST_ERR: begin
                        if (line_se0_c) begin
                            se0_cnt_q <= SE0_W'(1);
                            j_cnt_q   <= '0;
                        end else if (line_j_c) begin
                            j_cnt_q <= j_cnt_q + JCNT_W'(1);
                        end else begin
                            se0_cnt_q <= '0;
                            j_cnt_q   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign pkt_start = pkt_start_q;
    assign sync_ok   = sync_ok_q;
    assign pkt_done  = pkt_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign bit_count = bit_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: packets, stuffing, and each error path.
module tb_usb_rx_decoder;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       dp = 1'b1;
    logic       dm = 1'b0;
    logic       bit_out, bit_valid, pkt_start, sync_ok, pkt_done, err, busy;
    logic [2:0] err_code;
    logic [6:0] bit_count;

    int   checks = 0;
    int   errors = 0;
    logic tb_prev_j = 1'b1;
    logic [7:0] sync_pat = 8'b0000_0001;
    logic [7:0] pid      = 8'b1000_0111;

    usb_rx_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .dp        (dp),
        .dm        (dm),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .pkt_start (pkt_start),
        .sync_ok   (sync_ok),
        .pkt_done  (pkt_done),
        .err       (err),
        .err_code  (err_code),
        .bit_count (bit_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one line sample, let the DUT sample it, then settle past the edge
    task automatic drive(input logic [1:0] l);
        {dp, dm} = l;
        @(posedge clk);
        #1;
        if (l == LJ) tb_prev_j = 1'b1;
        if (l == LK) tb_prev_j = 1'b0;
    endtask

    // NRZI-encode one decoded bit and check forwarding
    task automatic tx_bit(input logic b, input logic exp_valid);
        logic cur_j;
        cur_j = b ? tb_prev_j : ~tb_prev_j;
        drive(cur_j ? LJ : LK);
        chk("bit_valid", 32'(bit_valid), 32'(exp_valid));
        if (exp_valid) chk("bit_out", 32'(bit_out), 32'(b));
    endtask

    task automatic send_sync(input int start);
        for (int i = start; i < 8; i++) begin
            tx_bit(sync_pat[7-i], 1'b1);
            if (i == 0) chk("pkt_start", 32'(pkt_start), 32'd1);
            if (i == 7) chk("sync_ok", 32'(sync_ok), 32'd1);
            if (i == 3) chk("sync_ok_early", 32'(sync_ok), 32'd0);
        end
    endtask

    task automatic recover();
        drive(LSE0);
        drive(LJ);
        chk("recover_busy", 32'(busy), 32'd0);
        drive(LJ);
    endtask

    initial begin
        // Reset state
        drive(LJ);
        drive(LJ);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        drive(LJ);
        chk("idle_j_busy", 32'(busy), 32'd0);

        // Full packet: SYNC + PID 10000111 + EOP
        send_sync(0);
        chk("sync_busy", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) tx_bit(pid[i], 1'b1);
        chk("pid_count", 32'(bit_count), 32'd16);
        drive(LSE0);
        chk("eop_no_valid", 32'(bit_valid), 32'd0);
        chk("eop_busy", 32'(busy), 32'd1);
        drive(LSE0);
        chk("eop2_done", 32'(pkt_done), 32'd0);
        drive(LJ);
        chk("pkt_done", 32'(pkt_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        chk("done_count", 32'(bit_count), 32'd16);
        drive(LJ);
        chk("done_pulse", 32'(pkt_done), 32'd0);

        // Stuffing: 0, 111111, stuffed 0 dropped, then 1
        send_sync(0);
        tx_bit(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tx_bit(1'b1, 1'b1);
        tx_bit(1'b0, 1'b0);
        chk("stuff_err", 32'(err), 32'd0);
        tx_bit(1'b1, 1'b1);
        chk("stuff_count", 32'(bit_count), 32'd16);
        drive(LSE0);
        drive(LSE0);
        drive(LJ);
        chk("stuff_done", 32'(pkt_done), 32'd1);
        drive(LJ);

        // Stuff violation: seven decoded 1s
        send_sync(0);
        tx_bit(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tx_bit(1'b1, 1'b1);
        tx_bit(1'b1, 1'b0);
        chk("stuff1_err", 32'(err), 32'd1);
        chk("stuff1_code", 32'(err_code), 32'd1);
        chk("stuff1_busy", 32'(busy), 32'd1);
        drive(LSE0);
        chk("stuff1_pulse", 32'(err), 32'd0);
        chk("stuff1_busy2", 32'(busy), 32'd1);
        drive(LJ);
        chk("stuff1_idle", 32'(busy), 32'd0);
        chk("stuff1_hold", 32'(err_code), 32'd1);
        chk("stuff1_count", 32'(bit_count), 32'd15);
        drive(LJ);

        // SYNC mismatch: line K,J,K,J,J
        for (int i = 0; i < 4; i++) tx_bit(1'b0, 1'b1);
        tx_bit(1'b1, 1'b0);
        chk("sync_err", 32'(err), 32'd1);
        chk("sync_code", 32'(err_code), 32'd2);
        chk("sync_no_ok", 32'(sync_ok), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(LJ);
            if (i == 6) chk("sync_err_busy7", 32'(busy), 32'd1);
        end
        chk("sync_j8_idle", 32'(busy), 32'd0);

        // Short EOP: single SE0 then J
        send_sync(0);
        tx_bit(1'b0, 1'b1);
        drive(LSE0);
        drive(LJ);
        chk("eop_err", 32'(err), 32'd1);
        chk("eop_code", 32'(err_code), 32'd3);
        chk("eop_no_done", 32'(pkt_done), 32'd0);
        recover();

        // Overflow: 99 bits fine, 100th rejected
        send_sync(0);
        for (int i = 0; i < 91; i++) tx_bit(1'b0, 1'b1);
        chk("ovf_count99", 32'(bit_count), 32'd99);
        chk("ovf_no_err", 32'(err), 32'd0);
        tx_bit(1'b0, 1'b0);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_code", 32'(err_code), 32'd4);
        chk("ovf_count", 32'(bit_count), 32'd99);
        recover();

        // SE1 in DATA
        send_sync(0);
        tx_bit(1'b1, 1'b1);
        drive(LSE1);
        chk("se1_err", 32'(err), 32'd1);
        chk("se1_code", 32'(err_code), 32'd5);
        chk("se1_no_valid", 32'(bit_valid), 32'd0);
        recover();

        // rx_en low aborts silently
        send_sync(0);
        rx_en = 1'b0;
        drive(LJ);
        chk("rxen_busy", 32'(busy), 32'd0);
        chk("rxen_err", 32'(err), 32'd0);
        rx_en = 1'b1;
        drive(LJ);

        // Asynchronous reset mid-DATA, then a fresh packet
        send_sync(0);
        tx_bit(1'b1, 1'b1);
        tx_bit(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bit_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(bit_valid), 32'd0);
        chk("arst_code", 32'(err_code), 32'd0);
        {dp, dm} = LJ;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_prev_j = 1'b1;
        chk("arst_err", 32'(err), 32'd0);
        tx_bit(1'b0, 1'b1);
        chk("arst_start", 32'(pkt_start), 32'd1);
        chk("arst_count1", 32'(bit_count), 32'd1);
        send_sync(1);
        drive(LSE0);
        drive(LSE0);
        drive(LJ);
        chk("arst_done", 32'(pkt_done), 32'd1);
        chk("arst_final", 32'(bit_count), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
- Receive-side line decoder: samples the raw D+/D- pair once per clock, detects packet start and SYNC, and NRZI-decodes the line.
- Removes stuffed bits and detects EOP.
- Delivers a clean serial bitstream plus a bit-valid strobe directly into the SIPO deserializer (bit_out -> inBit, bit_valid -> en).
- Flags line, sync, stuffing, EOP and length errors to the protocol FSM, which clears the SIPO on pkt_start/err.

Parameters:
SYNC_PATTERN, 8'b00000001, decoded SYNC, compared MSB first
STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is mandatory
EOP_SE0_MIN, 2, minimum consecutive SE0 samples for a valid EOP
MAX_BITS, 99, maximum forwarded bits per packet (SYNC included)
IDLE_J_LEN, 8, consecutive J samples that return ERR to IDLE

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
rx_en  in  1  decoder enable; low forces IDLE
dp  in  1  D+ line sample
dm  in  1  D- line sample
bit_out  out  1  decoded, unstuffed bit (valid with bit_valid)
bit_valid  out  1  one-cycle strobe per forwarded bit
pkt_start  out  1  pulse with the first SYNC bit
sync_ok  out  1  pulse with the 8th SYNC bit when the pattern matched
pkt_done  out  1  pulse when EOP completes (SE0 x EOP_SE0_MIN then J)
err  out  1  one-cycle error pulse
err_code  out  3  1 stuff, 2 sync, 3 eop, 4 overflow, 5 SE1; held until next err
bit_count  out  7  bits forwarded in current packet
busy  out  1  state != IDLE

Behaviour:
- Line states: J = (dp=1, dm=0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- Reset: all outputs 0; state IDLE; prev_line = J; ones_cnt = 0; sync_cnt = 0; se0_cnt = 0; j_cnt = 0. Reset mid-packet aborts silently, with no err and no pkt_done.
- Latency: all outputs registered. A sample taken at edge n appears on the outputs after edge n; one bit per clock max.
- NRZI decoding, J/K samples only: decoded = 1 if line == prev_line, else 0. prev_line updates on every J/K sample, in all states.
- IDLE:
  - J: stay.
  - K: bit_out = 0, bit_valid, pkt_start, bit_count = 1, sync_cnt = 1; go to SYNC.
  - SE0 and SE1: ignored.
- SYNC:
  - Each decoded bit is forwarded and compared to SYNC_PATTERN[7 - sync_cnt].
  - Mismatch: err, code 2; go to ERR. The mismatched bit is not forwarded.
  - When the 8th bit matches: sync_ok pulse; go to DATA.
- DATA: decoded bits are forwarded and bit_count increments.
- Unstuffing, in SYNC and DATA:
  - ones_cnt counts consecutive decoded 1s and clears on 0.
  - When ones_cnt == STUFF_LEN, the next bit must be 0. That bit is dropped (bit_valid low, bit_count unchanged) and ones_cnt clears.
  - If that bit is 1 instead: err, code 1; go to ERR.
- Overflow: a forwarded bit that would make bit_count > MAX_BITS gives err, code 4; go to ERR. The bit is not forwarded.
- SE0 in DATA: go to EOP with se0_cnt = 1; no bit emitted. SE0 in SYNC gives err, code 3.
- EOP:
  - SE0: se0_cnt++, saturating.
  - J with se0_cnt >= EOP_SE0_MIN: pkt_done; go to IDLE.
  - J with se0_cnt < EOP_SE0_MIN, or K: err, code 3; go to ERR.
  - prev_line = J on exit.
- SE1 in SYNC, DATA or EOP: err, code 5; go to ERR.
- ERR:
  - No bit_valid.
  - Leaves to IDLE on SE0 followed by J, or after IDLE_J_LEN consecutive J samples.
- rx_en low: next state IDLE; no pulses; prev_line still tracks. No err is raised for the abort.
- Simultaneous events: the err priorities are SE1 > stuff > sync > overflow. Only one err pulse per packet.
- bit_count clears only on pkt_start and reset; it holds after pkt_done or err so the FSM can read it.

Test Plan:
- Reset asserted mid-DATA -> all outputs 0 immediately (async); next K starts a fresh packet with bit_count = 1.
- Line J,K,J,K,J,K,J,K,K then NRZI of PID 8'b10000111, then SE0,SE0,J -> bits 00000001 10000111 on bit_valid, sync_ok on the 8th, bit_count = 16, pkt_done one cycle after the J sample, busy low after.
- DATA with decoded 1111110 then 1 -> six 1s forwarded, stuffed 0 dropped (bit_valid low that cycle), following 1 forwarded, bit_count +7, no err.
- DATA with seven decoded 1s -> six forwarded, err = 1 with err_code = 1 on the 7th, state ERR; SE0,J -> busy low.
- SYNC line K,J,K,J,J -> err_code = 2 on the 5th bit, no sync_ok; 8 J samples -> IDLE.
- Single SE0 then J, and separately 100 valid bits -> err_code 3 and err_code 4 respectively; also SE1 in DATA -> err_code 5.
